instr_fetch: RTL and testbench

- Front-end fetch stage feeding the execute/ALU stage.
- Fetches 32-bit words from instruction ROM through a valid handshake and holds them in a 4-halfword buffer.
- Splits the stream into 32-bit and compressed 16-bit instructions, presenting IR / IR_C / OPCODE / PC with a valid/ready handshake.
- Accepts a single PC redirect from the branch-resolution logic.

---
 rtl/instr_fetch.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch front end: ROM word fetch into a 4-halfword buffer, split into 32-bit / compressed instructions.
// Build option: define FETCH_C_EN to decode compressed instructions; without it every head is a 32-bit instruction.
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oROM_RD,
    output logic [7:0]  oROM_ADDR,
    input  logic [31:0] iROM_DATA,
    input  logic        iROM_VALID,
    input  logic        iREDIR,
    input  logic [7:0]  iREDIR_PC,
    output logic        oVALID,
    input  logic        iREADY,
    output logic [7:0]  oPC,
    output logic [31:0] oIR,
    output logic [15:0] oIR_C,
    output logic [6:0]  oOPCODE,
    output logic        oILL
);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t            state_reg, state_next;
    logic [7:0]        pc_reg, pc_next;
    logic [7:0]        fa_reg, fa_next;
    logic              sk_reg, sk_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [3:0][15:0]  buf_reg, buf_next;
    logic [3:0][15:0]  shift_buf;

    logic              head_is32;
    logic [2:0]        need;
    logic              head_valid;
    logic              fire;
    logic [2:0]        used;
    logic [2:0]        cnt_left;
    logic [2:0]        added;
    logic              append;

`ifdef FETCH_C_EN
    assign head_is32 = (buf_reg[0][1:0] == 2'b11);
`else
    assign head_is32 = 1'b1;
`endif

    assign need       = head_is32 ? 3'd2 : 3'd1;
    assign head_valid = (cnt_reg >= need);
    // A redirect in the same cycle overrides the consume.
    assign fire       = head_valid && iREADY && !iREDIR;
    assign used       = fire ? need : 3'd0;
    assign cnt_left   = cnt_reg - used;
    assign append     = (state_reg == WAIT) && iROM_VALID && !iREDIR;
    assign added      = !append ? 3'd0 : (sk_reg ? 3'd1 : 3'd2);

    // Per-slot shift by the consumed length, then append the fetched halfwords after the survivors.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            localparam logic [2:0] SLOT = 3'(gi);
            if (gi < 2) begin : g_full
                assign shift_buf[gi] = (used == 3'd2) ? buf_reg[gi+2] :
                                       (used == 3'd1) ? buf_reg[gi+1] : buf_reg[gi];
            end else if (gi < 3) begin : g_part
                assign shift_buf[gi] = (used != 3'd0) ? buf_reg[3] : buf_reg[2];
            end else begin : g_last
                assign shift_buf[gi] = buf_reg[3];
            end

            assign buf_next[gi] = !append ? shift_buf[gi] :
                                  sk_reg  ? ((cnt_left == SLOT) ? iROM_DATA[31:16] : shift_buf[gi]) :
                                  (cnt_left == SLOT)         ? iROM_DATA[15:0]  :
                                  (cnt_left + 3'd1 == SLOT)  ? iROM_DATA[31:16] : shift_buf[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fa_next    = fa_reg;
        sk_next    = sk_reg;
        cnt_next   = cnt_left + added;

        if (fire) begin
            pc_next = pc_reg + (head_is32 ? 8'd4 : 8'd2);
        end

        case (state_reg)
            IDLE: begin
                if (!iREDIR && cnt_left <= 3'd2) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (iROM_VALID) begin
                    state_next = IDLE;
                    if (!iREDIR) begin
                        fa_next = fa_reg + 8'd4;
                        sk_next = 1'b0;
                    end
                end else if (iREDIR) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (iROM_VALID) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (iREDIR) begin
            cnt_next = 3'd0;
            pc_next  = iREDIR_PC & 8'hFE;
            fa_next  = {iREDIR_PC[7:2], 2'b00};
            sk_next  = iREDIR_PC[1];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC & 8'hFE;
            fa_reg    <= {RESET_PC[7:2], 2'b00};
            sk_reg    <= RESET_PC[1];
            cnt_reg   <= 3'd0;
            buf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            fa_reg    <= fa_next;
            sk_reg    <= sk_next;
            cnt_reg   <= cnt_next;
            buf_reg   <= buf_next;
        end
    end

    assign oROM_RD   = (state_reg != IDLE);
    assign oROM_ADDR = fa_reg;
    assign oVALID    = head_valid;
    assign oPC       = pc_reg;

    always_comb begin
        oIR = 32'h0000_0013;
        if (head_valid && head_is32) begin
            oIR = {buf_reg[1], buf_reg[0]};
        end
    end

    assign oOPCODE = oIR[6:0];

`ifdef FETCH_C_EN
    assign oIR_C = (head_valid && !head_is32) ? buf_reg[0] : 16'hFFFF;
    assign oILL  = 1'b0;
`else
    // Marks the first instruction after a redirect to a halfword-aligned target.
    logic ill_first_reg;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            ill_first_reg <= 1'b0;
        end else if (iREDIR) begin
            ill_first_reg <= iREDIR_PC[1];
        end else if (fire) begin
            ill_first_reg <= 1'b0;
        end
    end

    assign oIR_C = 16'hFFFF;
    assign oILL  = head_valid && ((buf_reg[0][1:0] != 2'b11) || ill_first_reg);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, directed multi-cycle sequences and a randomized run against an instruction-stream model.
module tb_instr_fetch;

`ifdef FETCH_C_EN
    localparam bit C_EN = 1'b1;
`else
    localparam bit C_EN = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        oROM_RD;
    logic [7:0]  oROM_ADDR;
    logic [31:0] iROM_DATA;
    logic        iROM_VALID;
    logic        iREDIR;
    logic [7:0]  iREDIR_PC;
    logic        oVALID;
    logic        iREADY;
    logic [7:0]  oPC;
    logic [31:0] oIR;
    logic [15:0] oIR_C;
    logic [6:0]  oOPCODE;
    logic        oILL;

    always #5 iCLK = ~iCLK;

    instr_fetch #(.RESET_PC(8'h00)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .oROM_RD(oROM_RD), .oROM_ADDR(oROM_ADDR),
        .iROM_DATA(iROM_DATA), .iROM_VALID(iROM_VALID),
        .iREDIR(iREDIR), .iREDIR_PC(iREDIR_PC),
        .oVALID(oVALID), .iREADY(iREADY),
        .oPC(oPC), .oIR(oIR), .oIR_C(oIR_C), .oOPCODE(oOPCODE), .oILL(oILL)
    );

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;
    int rom_lat = 1;
    int rom_cnt = 0;
    bit rand_lat = 1'b0;
    logic [7:0] m_pc = 8'h00;
    bit m_first = 1'b0;
    int xfers = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] ir;
        logic [15:0] irc;
        logic        ill;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] hw(input logic [7:0] p);
        logic [31:0] w;
        w = mem[p[7:2]];
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    // Expected next instruction purely from memory contents and the architectural PC.
    task automatic model_expect(output logic [31:0] ir, output logic [15:0] irc,
                                output logic ill, output logic [7:0] len);
        logic [15:0] h, h2;
        logic [7:0]  p2;
        p2 = m_pc + 8'd2;
        h  = hw(m_pc);
        h2 = hw(p2);
        if (C_EN && h[1:0] != 2'b11) begin
            ir = 32'h0000_0013; irc = h; ill = 1'b0; len = 8'd2;
        end else begin
            ir = {h2, h}; irc = 16'hFFFF; len = 8'd4;
            ill = !C_EN && ((h[1:0] != 2'b11) || m_first);
        end
    endtask

    task automatic monitor();
        logic [31:0] e_ir;
        logic [15:0] e_irc;
        logic        e_ill;
        logic [7:0]  e_len;
        if (!iRST) begin
            m_pc = 8'h00;
            m_first = 1'b0;
        end else if (iREDIR) begin
            m_pc = iREDIR_PC & 8'hFE;
            m_first = iREDIR_PC[1];
        end else if (oVALID && iREADY) begin
            model_expect(e_ir, e_irc, e_ill, e_len);
            $display("XFER pc=%h ir=%h irc=%h ill=%b", oPC, oIR, oIR_C, oILL);
            chk("xfer_pc", oPC, m_pc);
            chk("xfer_ir", oIR, e_ir);
            chk("xfer_irc", oIR_C, e_irc);
            chk("xfer_opcode", oOPCODE, e_ir[6:0]);
            chk("xfer_ill", oILL, e_ill);
            m_pc = m_pc + e_len;
            m_first = 1'b0;
            xfers++;
        end
    endtask

    task automatic rom_step();
        if (!iRST) begin
            iROM_VALID = 1'b0;
            rom_cnt = 0;
        end else if (iROM_VALID) begin
            iROM_VALID = 1'b0;
            iROM_DATA = $urandom;
        end else if (oROM_RD) begin
            rom_cnt++;
            if (rom_cnt >= rom_lat) begin
                iROM_VALID = 1'b1;
                iROM_DATA = mem[oROM_ADDR[7:2]];
                rom_cnt = 0;
                if (rand_lat) rom_lat = $urandom_range(1, 3);
            end
        end
    endtask

    // Called at a falling edge with inputs set for the coming rising edge.
    task automatic run_cycle();
        monitor();
        @(posedge iCLK);
        @(negedge iCLK);
        rom_step();
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n;
        n = 0;
        while (!oVALID && n < limit) begin
            run_cycle();
            n++;
        end
        chk(name, oVALID, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_rd"}, oROM_RD, 1'b0);
        chk({tag, "_rom_addr"}, oROM_ADDR, 8'h00);
        chk({tag, "_valid"}, oVALID, 1'b0);
        chk({tag, "_ir"}, oIR, 32'h0000_0013);
        chk({tag, "_irc"}, oIR_C, 16'hFFFF);
        chk({tag, "_opcode"}, oOPCODE, 7'h13);
        chk({tag, "_ill"}, oILL, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw_low;
        int  x0;
        logic [5:0] idx;

        tbl[0] = '{8'h40, 32'h0050_0093, 32'h0000_0013, 32'h0050_0093, 16'hFFFF, 1'b0};
`ifdef FETCH_C_EN
        tbl[1] = '{8'h44, 32'h0505_4501, 32'h0000_0013, 32'h0000_0013, 16'h4501, 1'b0};
        tbl[2] = '{8'h4A, 32'h0093_1234, 32'hABCD_0050, 32'h0050_0093, 16'hFFFF, 1'b0};
        tbl[3] = '{8'h52, 32'h4501_FFFF, 32'h0000_1111, 32'h0000_0013, 16'h4501, 1'b0};
        tbl[4] = '{8'hFE, 32'h0093_0000, 32'h1234_0050, 32'h0050_0093, 16'hFFFF, 1'b0};
        tbl[5] = '{8'h60, 32'h0001_0002, 32'h0000_0013, 32'h0000_0013, 16'h0002, 1'b0};
`else
        tbl[1] = '{8'h44, 32'h0505_4501, 32'h0000_0013, 32'h0505_4501, 16'hFFFF, 1'b1};
        tbl[2] = '{8'h4A, 32'h0093_1234, 32'hABCD_0050, 32'h0050_0093, 16'hFFFF, 1'b1};
        tbl[3] = '{8'h52, 32'h4501_FFFF, 32'h0000_1111, 32'h1111_4501, 16'hFFFF, 1'b1};
        tbl[4] = '{8'hFE, 32'h0093_0000, 32'h1234_0050, 32'h0050_0093, 16'hFFFF, 1'b1};
        tbl[5] = '{8'h60, 32'h0001_0002, 32'h0000_0013, 32'h0001_0002, 16'hFFFF, 1'b1};
`endif

        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0050_0093;
        iRST = 1'b0; iREADY = 1'b0; iREDIR = 1'b0; iREDIR_PC = 8'h00;
        iROM_VALID = 1'b0; iROM_DATA = 32'h0;
        repeat (3) @(negedge iCLK);
        chk_reset_outputs("rst");

        // Reset release, first fetch and first 32-bit instruction.
        iRST = 1'b1; iREADY = 1'b1;
        run_cycle();
        chk("t1_rom_rd", oROM_RD, 1'b1);
        chk("t1_rom_addr", oROM_ADDR, 8'h00);
        wait_valid(20, "t1_valid");
        chk("t1_ir", oIR, 32'h0050_0093);
        chk("t1_irc", oIR_C, 16'hFFFF);
        chk("t1_pc", oPC, 8'h00);
        run_cycle();
        chk("t1_next_pc", oPC, 8'h04);

        // Vector table: redirect to each target and check the first presented instruction.
        foreach (tbl[k]) begin
            iREADY = 1'b0;
            idx = tbl[k].pc[7:2];
            mem[idx] = tbl[k].w0;
            idx = idx + 6'd1;
            mem[idx] = tbl[k].w1;
            iREDIR = 1'b1; iREDIR_PC = tbl[k].pc;
            run_cycle();
            iREDIR = 1'b0;
            chk("tbl_valid_after_redir", oVALID, 1'b0);
            wait_valid(40, "tbl_valid");
            chk("tbl_pc", oPC, tbl[k].pc & 8'hFE);
            chk("tbl_ir", oIR, tbl[k].ir);
            chk("tbl_irc", oIR_C, tbl[k].irc);
            chk("tbl_opcode", oOPCODE, tbl[k].ir[6:0]);
            chk("tbl_ill", oILL, tbl[k].ill);
            iREADY = 1'b1;
            run_cycle();
        end

        // Redirect while a slow fetch is outstanding: stale word dropped, refetch from 0x20.
        iREADY = 1'b0;
        iRST = 1'b0;
        repeat (2) run_cycle();
        rom_lat = 3;
        mem[8] = 32'h0093_5555;
        mem[9] = 32'h7777_0050;
        iRST = 1'b1;
        n = 0;
        while (!oROM_RD && n < 10) begin run_cycle(); n++; end
        chk("t4_req_pending", oROM_RD, 1'b1);
        iREDIR = 1'b1; iREDIR_PC = 8'h22;
        run_cycle();
        iREDIR = 1'b0;
        chk("t4_drop_rd_held", oROM_RD, 1'b1);
        chk("t4_valid_after_redir", oVALID, 1'b0);
        saw_low = 1'b0;
        n = 0;
        while (!(oROM_RD && saw_low) && n < 20) begin
            if (!oROM_RD) saw_low = 1'b1;
            run_cycle();
            n++;
        end
        chk("t4_new_req", oROM_RD && saw_low, 1'b1);
        chk("t4_new_addr", oROM_ADDR, 8'h20);
        wait_valid(40, "t4_valid");
        chk("t4_pc", oPC, 8'h22);
        chk("t4_ir", oIR, 32'h0050_0093);
        chk("t4_ill", oILL, !C_EN);
        iREADY = 1'b1;
        run_cycle();

        // Stall with the buffer filling, then drain and check contiguity.
        rom_lat = 1;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        iREADY = 1'b0;
        iREDIR = 1'b1; iREDIR_PC = 8'h80;
        run_cycle();
        iREDIR = 1'b0;
        repeat (10) run_cycle();
        chk("t5_rom_rd_idle", oROM_RD, 1'b0);
        chk("t5_valid_held", oVALID, 1'b1);
        chk("t5_pc_held", oPC, 8'h80);
        x0 = xfers;
        iREADY = 1'b1;
        repeat (30) run_cycle();
        chk("t5_progress", (xfers - x0) >= 10, 1'b1);

        // Reset in the middle of an outstanding fetch.
        rom_lat = 3;
        iREDIR = 1'b1; iREDIR_PC = 8'h10;
        run_cycle();
        iREDIR = 1'b0;
        n = 0;
        while (!oROM_RD && n < 10) begin run_cycle(); n++; end
        chk("t6_req_pending", oROM_RD, 1'b1);
        iRST = 1'b0;
        #1;
        chk_reset_outputs("t6");
        repeat (2) run_cycle();
        rom_lat = 1;
        iRST = 1'b1;
        run_cycle();
        chk("t6_restart_rd", oROM_RD, 1'b1);
        chk("t6_restart_addr", oROM_ADDR, 8'h00);
        wait_valid(20, "t6_valid");
        chk("t6_pc", oPC, 8'h00);

        // Randomized run against the stream model.
        rand_lat = 1'b1;
        x0 = xfers;
        for (int c = 0; c < 1500; c++) begin
            iREADY = ($urandom_range(0, 3) != 0);
            iREDIR = ($urandom_range(0, 39) == 0);
            iREDIR_PC = 8'($urandom);
            run_cycle();
        end
        iREDIR = 1'b0;
        chk("rand_progress", (xfers - x0) >= 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
